// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: FSM state encoding and
// the iteration-counter width helper.
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter must be able to hold the value WIDTH itself.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mult_add_shift_step.sv
// One radix-2 iteration: conditionally add the multiplicand into the upper
// accumulator half, then shift {carry, upper, lower} right by one bit.
module mult_add_shift_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]   i_mcand,
  input  logic [2*WIDTH-1:0] i_acc,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [WIDTH:0] w_sum;

  always_comb begin
    w_sum = {1'b0, i_acc[2*WIDTH-1:WIDTH]} +
            (i_acc[0] ? {1'b0, i_mcand} : {(WIDTH+1){1'b0}});
    // The adder carry becomes the new MSB; the examined multiplier bit drops out.
    o_acc = {w_sum, i_acc[WIDTH-1:1]};
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add multiplier, WIDTH cycles per product, valid/ready
// handshakes on both sides. Define SHIFT_ADD_MULT_SIGNED_EN to add is_signed.
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
`ifdef SHIFT_ADD_MULT_SIGNED_EN
  input  logic               is_signed,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               busy
);

  localparam int             CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_mcand;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_p;
  logic [CNT_W-1:0]     r_cnt;
  logic                 w_accept;
  logic                 w_last;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [2*WIDTH-1:0]   w_acc_nxt;
  logic [2*WIDTH-1:0]   w_prod;

  assign w_accept = in_valid && (r_state == ST_IDLE);
  assign w_last   = (r_state == ST_BUSY) && (r_cnt == LAST);

`ifdef SHIFT_ADD_MULT_SIGNED_EN
  logic r_neg;
  logic w_neg;

  // Multiply magnitudes; the most negative value maps to 2^(WIDTH-1), which still fits unsigned.
  assign w_a_mag = (is_signed && in_a[WIDTH-1]) ? (~in_a + WIDTH'(1)) : in_a;
  assign w_b_mag = (is_signed && in_b[WIDTH-1]) ? (~in_b + WIDTH'(1)) : in_b;
  assign w_neg   = is_signed && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
  assign w_prod  = r_neg ? (~w_acc_nxt + (2*WIDTH)'(1)) : w_acc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_neg <= 1'b0;
    end else if (w_accept) begin
      r_neg <= w_neg;
    end
  end
`else
  assign w_a_mag = in_a;
  assign w_b_mag = in_b;
  assign w_prod  = w_acc_nxt;
`endif

  mult_add_shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_mcand (r_mcand),
    .i_acc   (r_acc),
    .o_acc   (w_acc_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (in_valid) w_state_nxt = ST_BUSY;
      ST_BUSY: if (w_last)   w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Lower accumulator half starts as the multiplier and is consumed LSB-first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_p     <= '0;
    end else if (w_accept) begin
      r_mcand <= w_a_mag;
      r_acc   <= {{WIDTH{1'b0}}, w_b_mag};
      r_cnt   <= '0;
    end else if (r_state == ST_BUSY) begin
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_p <= w_prod;
      end
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = (r_state == ST_BUSY);
  assign out_valid = (r_state == ST_DONE);
  assign out_p     = r_p;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Randomized self-checking bench for shift_add_multiplier (WIDTH=4) against a
// transaction-level model; signed cases run when SHIFT_ADD_MULT_SIGNED_EN is defined.
module tb_shift_add_multiplier;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [W-1:0]   in_a = '0;
  logic [W-1:0]   in_b = '0;
  logic           s_mode = 1'b0;
  logic           in_ready;
  logic           out_valid;
  logic           busy;
  logic [2*W-1:0] out_p;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  shift_add_multiplier #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
`ifdef SHIFT_ADD_MULT_SIGNED_EN
    .is_signed (s_mode),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .busy      (busy)
  );

`ifdef SHIFT_ADD_MULT_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Exact product from plain integer arithmetic.
  function automatic logic [2*W-1:0] model_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input bit s);
    int ia;
    int ib;
    int p;
    ia = int'(a);
    ib = int'(b);
    if (s && a[W-1]) ia = ia - (1 << W);
    if (s && b[W-1]) ib = ib - (1 << W);
    p = ia * ib;
    return p[2*W-1:0];
  endfunction

  // Transaction model: accepted pair is busy for W cycles, then held until out_ready.
  bit             m_busy;
  bit             m_done;
  int             m_left;
  logic [2*W-1:0] m_exp;
  logic [2*W-1:0] m_out;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_left <= 0;
      m_exp  <= '0;
      m_out  <= '0;
    end else if (m_done) begin
      if (out_ready) m_done <= 1'b0;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_out  <= m_exp;
      end
    end else if (in_valid) begin
      m_exp  <= model_prod(in_a, in_b, SIGNED_BUILD && s_mode);
      m_busy <= 1'b1;
      m_left <= W;
    end
  end

  always @(negedge clk) begin
    chk("in_ready", in_ready, !m_busy && !m_done);
    chk("busy", busy, m_busy);
    chk("out_valid", out_valid, m_done);
    chk("out_p", out_p, m_out);
  end

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                       input int hold, input bit noisy, input bit use_lit,
                       input logic [2*W-1:0] lit);
    int lat;
    bit got;
    in_a      = a;
    in_b      = b;
    s_mode    = s;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    for (int k = 1; k <= 4 * W + 10; k++) begin
      if (noisy) begin
        in_a     = W'($urandom);
        in_b     = W'($urandom);
        in_valid = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = k;
        got = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!got) chk("done_timeout", 0, 1);
    chk("latency", lat, W);
    if (use_lit) chk("product_lit", out_p, lit);
    for (int h = 0; h < hold; h++) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      if (use_lit) chk("hold_product", out_p, lit);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("idle_after_done", in_ready, 1);
    chk("valid_after_done", out_valid, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_p", out_p, 0);
    rst_n = 1'b1;

    do_op(4'd15, 4'd15, 1'b0, 0, 1'b0, 1'b1, 8'd225);
    do_op(4'd0,  4'd13, 1'b0, 0, 1'b0, 1'b1, 8'd0);
    do_op(4'd15, 4'd1,  1'b0, 1, 1'b0, 1'b1, 8'd15);
    do_op(4'd6,  4'd7,  1'b0, 5, 1'b0, 1'b1, 8'd42);
    do_op(4'd9,  4'd11, 1'b0, 0, 1'b1, 1'b1, 8'd99);

    // Abort an operation during its third BUSY cycle.
    in_a     = 4'd12;
    in_b     = 4'd13;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_abort_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_out_p", out_p, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_op(4'd3, 4'd5, 1'b0, 0, 1'b0, 1'b1, 8'd15);

    if (SIGNED_BUILD) begin
      do_op(4'h8, 4'h8, 1'b1, 0, 1'b0, 1'b1, 8'h40);
      do_op(4'hD, 4'h5, 1'b1, 1, 1'b0, 1'b1, 8'hF1);
      do_op(4'hD, 4'h5, 1'b0, 0, 1'b0, 1'b1, 8'd65);
    end

    for (int i = 0; i < 40; i++) begin
      do_op(W'($urandom), W'($urandom), SIGNED_BUILD && ($urandom_range(0, 1) == 1),
            $urandom_range(0, 2), ($urandom_range(0, 1) == 1), 1'b0, '0);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
